// File: rtl/gpu_pkg.sv
// gpu_pkg: shared primitive/scheduler types and screen constants
package gpu_pkg;
  localparam int ADDR_W = 19;
  localparam int POS_W = 38;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef enum logic {PRIM_CIRCLE = 1'b0, PRIM_LINE = 1'b1} prim_t;
  typedef enum logic [1:0] {IDLE, LAUNCH, DRAW, DRAIN} sched_state_t;
  // Addresses pack {x[9:0], y[8:0]}; wrapped negatives land far beyond the limits.
  function automatic logic in_bounds(input logic [ADDR_W-1:0] a, input int w, input int h);
    return (32'(a[18:9]) < 32'(w)) && (32'(a[8:0]) < 32'(h));
  endfunction
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous FIFO, power-of-two depth, combinational head read
//   push_i/wdata_i write side, pop_i/rdata_o read side,
//   full_o/empty_o flags, count_o occupancy (0..DEPTH)
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  assign rdata_o = mem_q[rd_q];
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/prim_scheduler.sv
// prim_scheduler: launches one rasterizer per command, clips its pixels, buffers and writes them
//   cmd_*            one-at-a-time command handshake from the decoder
//   eng_pos, *_start geometry and launch pulses to the circle/line engines
//   eng_stop         stall to the active engine while the pixel buffer is nearly full
//   circ_*/line_*    pixel streams and completion from the engines
//   fb_*             single framebuffer write port, fb_busy backpressure
//   busy, clip_cnt   status: not idle, saturating dropped-pixel count
module prim_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int COLOR_W = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_type,
  input  logic [gpu_pkg::POS_W-1:0]     cmd_pos,
  input  logic [COLOR_W-1:0]            cmd_color,
  output logic [gpu_pkg::POS_W-1:0]     eng_pos,
  output logic                          circ_start,
  output logic                          line_start,
  output logic                          eng_stop,
  input  logic [gpu_pkg::ADDR_W-1:0]    circ_addr,
  input  logic                          circ_pvalid,
  input  logic                          circ_done,
  input  logic [gpu_pkg::ADDR_W-1:0]    line_addr,
  input  logic                          line_pvalid,
  input  logic                          line_done,
  output logic [gpu_pkg::ADDR_W-1:0]    fb_addr,
  output logic [COLOR_W-1:0]            fb_data,
  output logic                          fb_we,
  input  logic                          fb_busy,
  output logic                          busy,
  output logic [15:0]                   clip_cnt
);
  import gpu_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = ADDR_W + COLOR_W;
  sched_state_t state_q, state_d;
  prim_t type_q;
  logic [POS_W-1:0] pos_q;
  logic [COLOR_W-1:0] color_q;
  logic [15:0] clip_q, clip_d;
  logic sel_pvalid, sel_done, take, visible, push, pop;
  logic [ADDR_W-1:0] sel_addr;
  logic fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] head;
  // Only the launched engine is listened to; the idle one may chatter freely.
  assign sel_pvalid = type_q == PRIM_LINE ? line_pvalid : circ_pvalid;
  assign sel_done = type_q == PRIM_LINE ? line_done : circ_done;
  assign sel_addr = type_q == PRIM_LINE ? line_addr : circ_addr;
  assign take = state_q == DRAW && sel_pvalid;
  assign visible = in_bounds(sel_addr, SCREEN_W, SCREEN_H);
  assign push = take && visible;
  assign pop = !fifo_empty && !fb_busy;
  assign clip_d = (take && !visible && clip_q != 16'hFFFF) ? clip_q + 16'd1 : clip_q;
  always_comb begin
    state_d = state_q;
    cmd_ready = 1'b0;
    circ_start = 1'b0;
    line_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = LAUNCH;
      end
      LAUNCH: begin
        circ_start = type_q == PRIM_CIRCLE;
        line_start = type_q == PRIM_LINE;
        state_d = DRAW;
      end
      DRAW: if (sel_done) state_d = DRAIN;
      DRAIN: if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      type_q <= PRIM_CIRCLE;
      pos_q <= '0;
      color_q <= '0;
      clip_q <= '0;
    end else begin
      state_q <= state_d;
      clip_q <= clip_d;
      if (state_q == IDLE && cmd_valid) begin
        type_q <= prim_t'(cmd_type);
        pos_q <= cmd_pos;
        color_q <= cmd_color;
      end
    end
  end
  pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk(clk),
    .n_rst(n_rst),
    .push_i(push),
    .wdata_i({sel_addr, color_q}),
    .pop_i(pop),
    .rdata_o(head),
    .full_o(fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );
  // Stopping one entry early absorbs a pixel the engine issues in the cycle stop rises.
  assign eng_stop = fifo_count >= CW'(FIFO_DEPTH - 1);
  assign fb_we = pop;
  assign fb_addr = pop ? head[EW-1:COLOR_W] : '0;
  assign fb_data = pop ? head[COLOR_W-1:0] : '0;
  assign busy = state_q != IDLE;
  assign clip_cnt = clip_q;
  assign eng_pos = pos_q;
  no_push_when_full: assert property (@(posedge clk) disable iff (!n_rst) !(push && fifo_full));
endmodule

// File: tb/tb_prim_scheduler.sv
module tb_prim_scheduler;
  localparam int DEPTH = 4;
  localparam int SW = 640;
  localparam int SH = 480;
  logic clk = 0, n_rst = 0;
  logic cmd_valid = 0, cmd_ready, cmd_type = 0;
  logic [37:0] cmd_pos = '0, eng_pos;
  logic [7:0] cmd_color = '0, fb_data;
  logic circ_start, line_start, eng_stop, fb_we, busy;
  logic [18:0] circ_addr = '0, line_addr = '0, fb_addr;
  logic circ_pvalid = 0, circ_done = 0, line_pvalid = 0, line_done = 0, fb_busy = 0;
  logic [15:0] clip_cnt;

  prim_scheduler #(.FIFO_DEPTH(DEPTH), .COLOR_W(8), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_pos(cmd_pos), .cmd_color(cmd_color),
    .eng_pos(eng_pos), .circ_start(circ_start), .line_start(line_start), .eng_stop(eng_stop),
    .circ_addr(circ_addr), .circ_pvalid(circ_pvalid), .circ_done(circ_done),
    .line_addr(line_addr), .line_pvalid(line_pvalid), .line_done(line_done),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_busy(fb_busy),
    .busy(busy), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [26:0] exp_q[$];
  logic [18:0] pix_q[$];
  int clip_exp = 0, circ_pulses = 0, line_pulses = 0, cp0 = 0, lp0 = 0, busy_hold = 0;
  bit noise = 0, rand_busy = 0;
  logic [7:0] cur_color = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(input int x, input int y);
    return {x[9:0], y[8:0]};
  endfunction

  function automatic bit on_screen(input logic [18:0] a);
    return (int'(a[18:9]) < SW) && (int'(a[8:0]) < SH);
  endfunction

  always @(negedge clk) begin
    if (circ_start === 1'b1) circ_pulses++;
    if (line_start === 1'b1) line_pulses++;
    if (fb_we === 1'b1) begin
      chk("fb_write_expected", 64'(exp_q.size() != 0), 64'd1);
      chk("fb_we_while_busy", 64'(fb_busy), 64'd0);
      if (exp_q.size() != 0) chk("fb_write", {fb_addr, fb_data}, exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (busy_hold > 0) begin
      busy_hold--;
      if (busy_hold == 0) fb_busy = 0;
    end else if (rand_busy) fb_busy = ($urandom_range(0, 2) == 0);
    if (noise) begin
      circ_pvalid = 1'($urandom);
      circ_done = 1'($urandom);
      circ_addr = 19'($urandom);
    end
  endtask

  task automatic send(input bit typ, input logic [37:0] pos, input logic [7:0] col, input bit keep);
    int t = 0;
    cmd_type = typ;
    cmd_pos = pos;
    cmd_color = col;
    cmd_valid = 1;
    while (!cmd_ready && t < 300) begin step(); t++; end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cur_color = col;
    cp0 = circ_pulses;
    lp0 = line_pulses;
    step();
    if (!keep) cmd_valid = 0;
    chk("launch_busy", 64'(busy), 64'd1);
    chk("launch_ready", 64'(cmd_ready), 64'd0);
    chk("eng_pos", 64'(eng_pos), 64'(pos));
    chk("circ_start", 64'(circ_start), 64'(typ == 0));
    chk("line_start", 64'(line_start), 64'(typ == 1));
    step();
    chk("start_one_cycle", 64'({circ_start, line_start}), 64'd0);
  endtask

  task automatic push_pixel(input bit typ, input logic [18:0] a, input bit done);
    if (on_screen(a)) exp_q.push_back({a, cur_color});
    else if (clip_exp < 65535) clip_exp++;
    if (typ) begin line_addr = a; line_pvalid = 1; line_done = done; end
    else begin circ_addr = a; circ_pvalid = 1; circ_done = done; end
    step();
    if (typ) begin line_pvalid = 0; line_done = 0; end
    else if (!noise) begin circ_pvalid = 0; circ_done = 0; end
  endtask

  task automatic draw(input bit typ, input bit done_last);
    int t;
    for (int i = 0; i < pix_q.size(); i++) begin
      t = 0;
      while (eng_stop && t < 500) begin step(); t++; end
      chk("stall_wait", 64'(eng_stop), 64'd0);
      push_pixel(typ, pix_q[i], done_last && i == pix_q.size() - 1);
      chk("eng_stop", 64'(eng_stop), 64'(exp_q.size() >= DEPTH - 1));
      chk("ready_low", 64'(cmd_ready), 64'd0);
    end
    if (!done_last || pix_q.size() == 0) begin
      if (typ) line_done = 1; else circ_done = 1;
      step();
      if (typ) line_done = 0; else circ_done = 0;
    end
    t = 0;
    while (busy && t < 500) begin
      chk("ready_low_drain", 64'(cmd_ready), 64'd0);
      step();
      t++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("clip_cnt", 64'(clip_cnt), 64'(clip_exp));
    chk("circ_pulses", 64'(circ_pulses - cp0), 64'(typ == 0));
    chk("line_pulses", 64'(line_pulses - lp0), 64'(typ == 1));
  endtask

  initial begin
    int n, x, y;
    bit typ;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fb_we", 64'(fb_we), 64'd0);
    chk("rst_fb_addr", 64'(fb_addr), 64'd0);
    chk("rst_clip", 64'(clip_cnt), 64'd0);
    chk("rst_eng_pos", 64'(eng_pos), 64'd0);
    chk("rst_starts", 64'({circ_start, line_start, eng_stop}), 64'd0);
    step();
    n_rst = 1;
    step();
    // 1: circle centre (100,100) radius 5
    pix_q = '{mk(105,100), mk(105,101), mk(104,103), mk(103,104), mk(101,105), mk(100,105),
              mk(95,100), mk(96,97), mk(100,95), mk(104,97)};
    send(0, {10'd100, 9'd100, 19'd5}, 8'hA5, 0);
    draw(0, 0);
    // 2: line with the circle engine chattering
    noise = 1;
    pix_q = '{mk(10,10), mk(11,11), mk(12,12), mk(13,13), mk(14,14), mk(15,15)};
    send(1, {10'd10, 9'd10, 10'd15, 9'd15}, 8'h3C, 0);
    draw(1, 1);
    noise = 0;
    circ_pvalid = 0; circ_done = 0; circ_addr = '0;
    // 3: framebuffer stalled for 50 cycles while drawing
    pix_q.delete();
    for (int i = 0; i < 9; i++) pix_q.push_back(mk(200 + i, 50));
    send(1, 38'h12345, 8'h77, 0);
    fb_busy = 1;
    busy_hold = 50;
    draw(1, 0);
    // 4: clip boundaries
    pix_q = '{mk(639,10), mk(640,10), mk(10,479), mk(10,480)};
    send(0, 38'h2, 8'h11, 0);
    draw(0, 1);
    chk("clip_delta", 64'(clip_cnt), 64'd2);
    // 5: cmd_valid held across two commands
    pix_q = '{mk(1,1), mk(2,2), mk(3,3)};
    send(0, 38'hAAAA, 8'h21, 1);
    cmd_type = 1; cmd_pos = 38'h5555; cmd_color = 8'h42;
    draw(0, 0);
    chk("held_valid_ready", 64'(cmd_ready), 64'd1);
    pix_q = '{mk(4,4), mk(5,5)};
    send(1, 38'h5555, 8'h42, 0);
    draw(1, 0);
    // 6: reset mid-DRAW with 3 buffered pixels
    send(1, 38'h777, 8'h99, 0);
    fb_busy = 1;
    for (int i = 0; i < 3; i++) push_pixel(1, mk(300 + i, 300), 0);
    chk("three_stop", 64'(eng_stop), 64'd1);
    n_rst = 0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_fb", 64'({fb_we, fb_addr, fb_data}), 64'd0);
    chk("mid_rst_stop", 64'(eng_stop), 64'd0);
    chk("mid_rst_pos", 64'(eng_pos), 64'd0);
    chk("mid_rst_clip", 64'(clip_cnt), 64'd0);
    exp_q.delete();
    clip_exp = 0;
    step();
    n_rst = 1;
    fb_busy = 0;
    for (int i = 0; i < 6; i++) step();
    pix_q = '{mk(7,7), mk(700,7), mk(8,8)};
    send(0, 38'h888, 8'h5A, 0);
    draw(0, 1);
    // random commands with random backpressure
    rand_busy = 1;
    for (int k = 0; k < 8; k++) begin
      typ = 1'($urandom);
      noise = typ;
      n = $urandom_range(1, 12);
      pix_q.delete();
      for (int i = 0; i < n; i++) begin
        x = ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 700);
        y = ($urandom_range(0, 9) == 0) ? 511 : $urandom_range(0, 520);
        pix_q.push_back(mk(x, y));
      end
      send(typ, 38'($urandom), 8'($urandom), 0);
      draw(typ, 1'($urandom));
      noise = 0;
      circ_pvalid = 0; circ_done = 0;
    end
    rand_busy = 0;
    fb_busy = 0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
